// File: rtl/counter_w_flag.sv
// counter_w_flag -- machine-cycle sequencer for the multi-cycle MIPS core.
//
// Free-running modulo counter whose value is the current processor phase.
// Leaves the idle value 0 after reset, then cycles 1..MAXIMUM_VALUE-1 and
// never returns to 0 except through reset. flag marks the last phase of
// each instruction.
//
// Optional feature, macro COUNTER_W_FLAG_CYCLE_CNT_EN:
//   adds output cycles[15:0], a wrapping count of completed instructions.
//
// Phase table (MAXIMUM_VALUE = 6):
//   value | meaning
//   ------+---------------------
//   0     | idle, after reset only
//   1     | FETCH
//   2     | DECODE
//   3     | EXECUTE
//   4     | WRITEBACK / UPDATEPC
//   5     | DUMMY (flag high)
module counter_w_flag #(
  parameter int MAXIMUM_VALUE = 6,
  parameter int NBITS         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic             flag,
`ifdef COUNTER_W_FLAG_CYCLE_CNT_EN
  output logic [15:0]      cycles,
`endif
  output logic [NBITS-1:0] counter
);

  // Last phase value in the counter's own width.
  localparam int              LAST_INT = MAXIMUM_VALUE - 1;
  localparam logic [NBITS-1:0] LAST    = LAST_INT[NBITS-1:0];
  localparam logic [NBITS-1:0] ONE     = NBITS'(1);

  // Reject parameter sets the counter cannot represent.
  generate
    if (MAXIMUM_VALUE < 2 || MAXIMUM_VALUE > (2 ** NBITS)) begin : g_bad_param
      $error("counter_w_flag: MAXIMUM_VALUE=%0d outside 2..2**NBITS (NBITS=%0d)",
             MAXIMUM_VALUE, NBITS);
    end
  endgenerate

  logic [NBITS-1:0] counter_nxt;

  // Next-phase decode: idle, last phase and any upset value all go to 1.
  always_comb begin
    counter_nxt = counter;
    if (enable) begin
      if (counter == '0 || counter >= LAST) begin
        counter_nxt = ONE;
      end else begin
        counter_nxt = counter + ONE;
      end
    end
  end

  // Phase register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else begin
      counter <= counter_nxt;
    end
  end

  // Last-phase decode straight off the register so the core sees it without
  // extra latency; LAST is at least 1, so idle never raises flag.
  always_comb begin
    flag = (counter == LAST);
  end

`ifdef COUNTER_W_FLAG_CYCLE_CNT_EN
  // Completed-instruction count: bumps when an enabled edge leaves the last phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= 16'd0;
    end else if (enable && flag) begin
      cycles <= cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_w_flag.sv
// Scoreboard bench for counter_w_flag: three instances (MAXIMUM_VALUE 6, 8
// and the degenerate 2) share one stimulus stream; expected phases are pushed
// when inputs are driven and popped after the clock edge.
module tb_counter_w_flag;

  logic clk;
  logic reset;
  logic enable;

  logic       flag6, flag8, flag2;
  logic [2:0] counter6, counter8, counter2;
`ifdef COUNTER_W_FLAG_CYCLE_CNT_EN
  logic [15:0] cycles6, cycles8, cycles2;
`endif

  counter_w_flag #(.MAXIMUM_VALUE(6), .NBITS(3)) dut6 (
    .clk(clk), .reset(reset), .enable(enable), .flag(flag6),
`ifdef COUNTER_W_FLAG_CYCLE_CNT_EN
    .cycles(cycles6),
`endif
    .counter(counter6)
  );

  counter_w_flag #(.MAXIMUM_VALUE(8), .NBITS(3)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .flag(flag8),
`ifdef COUNTER_W_FLAG_CYCLE_CNT_EN
    .cycles(cycles8),
`endif
    .counter(counter8)
  );

  counter_w_flag #(.MAXIMUM_VALUE(2), .NBITS(3)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .flag(flag2),
`ifdef COUNTER_W_FLAG_CYCLE_CNT_EN
    .cycles(cycles2),
`endif
    .counter(counter2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int c6; int f6;
    int c8; int f8;
    int c2; int f2;
    int y6;
  } exp_t;

  exp_t exp_q[$];

  int n_vec;
  int n_err;

  // model state
  int m6, m8, m2, y6;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int phase_next(input int c, input int maxv);
    if (c == 0) return 1;
    if (c >= maxv - 1) return 1;
    return c + 1;
  endfunction

  // One clock: drive inputs, push model expectation, check after the edge.
  task automatic step(input logic r, input logic e);
    exp_t x;
    reset  = r;
    enable = e;
    if (r) begin
      m6 = 0; m8 = 0; m2 = 0; y6 = 0;
    end else if (e) begin
      if (m6 == 5) y6 = (y6 + 1) % 65536;
      m6 = phase_next(m6, 6);
      m8 = phase_next(m8, 8);
      m2 = phase_next(m2, 2);
    end
    x.c6 = m6; x.f6 = (m6 == 5) ? 1 : 0;
    x.c8 = m8; x.f8 = (m8 == 7) ? 1 : 0;
    x.c2 = m2; x.f2 = (m2 == 1) ? 1 : 0;
    x.y6 = y6;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("counter6", int'(counter6), x.c6);
    chk("flag6",    int'(flag6),    x.f6);
    chk("counter8", int'(counter8), x.c8);
    chk("flag8",    int'(flag8),    x.f8);
    chk("counter2", int'(counter2), x.c2);
    chk("flag2",    int'(flag2),    x.f2);
`ifdef COUNTER_W_FLAG_CYCLE_CNT_EN
    chk("cycles6",  int'(cycles6),  x.y6);
`endif
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m6 = 0; m8 = 0; m2 = 0; y6 = 0;
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);

    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // 12 enabled clocks: 1,2,3,4,5,1,2,3,4,5,1,2
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    chk("seq12_end", int'(counter6), 2);

    // hold at 3 for three clocks, then 4,5,1
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("hold3", int'(counter6), 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk("after_hold3", int'(counter6), 1);

    // hold at 5: flag stays high, then wrap to 1
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);
    chk("hold5_flag", int'(flag6), 1);
    step(1'b0, 1'b1);
    chk("wrap_after_hold", int'(counter6), 1);

    // reset mid-period with enable high
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_mid", int'(counter6), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

    // long run from reset; also walks the 8-phase instance through its wrap
    step(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
